// File: rtl/exe_issue_ctrl.sv
// exe_issue_ctrl: uop FIFO plus RAW hazard tracker feeding the execution unit.
// The head uop is held until no source matches an in-flight destination, then
// issued through a registered issue stage. system_stall freezes the issue and
// tracker stages. flush clears everything.
module exe_issue_ctrl #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned HAZ_DEPTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     system_stall,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_instruction_type,
   input  logic [2:0]               in_funct3,
   input  logic [6:0]               in_funct7,
   input  logic [20:0]              in_immediate,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic                     in_uses_rs1,
   input  logic                     in_uses_rs2,
   input  logic                     in_writes_rd,
   output logic                     issue_valid,
   output logic [6:0]               issue_instruction_type,
   output logic [2:0]               issue_funct3,
   output logic [6:0]               issue_funct7,
   output logic [20:0]              issue_immediate,
   output logic [4:0]               issue_rs1,
   output logic [4:0]               issue_rs2,
   output logic [4:0]               issue_rd,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     hazard_stall
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [6:0]  instruction_type;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [20:0] immediate;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        uses_rs1;
      logic        uses_rs2;
      logic        writes_rd;
   } uop_t;

   uop_t             mem [DEPTH];
   uop_t             in_uop;
   uop_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             empty;
   logic             push;
   logic             issue_now;
   logic             hazard_c;
   logic             rs1_chk;
   logic             rs2_chk;

   // Pack the decode fields into one FIFO entry.
   always_comb begin
      in_uop                  = '0;
      in_uop.instruction_type = in_instruction_type;
      in_uop.funct3           = in_funct3;
      in_uop.funct7           = in_funct7;
      in_uop.immediate        = in_immediate;
      in_uop.rd               = in_rd;
      in_uop.rs1              = in_rs1;
      in_uop.rs2              = in_rs2;
      in_uop.uses_rs1         = in_uses_rs1;
      in_uop.uses_rs2         = in_uses_rs2;
      in_uop.writes_rd        = in_writes_rd;
   end

   assign in_ready     = (count != CNT_W'(DEPTH)) && !flush;
   assign push         = in_valid && in_ready;
   assign empty        = (count == '0);
   assign head         = mem[rd_ptr];
   assign rs1_chk      = head.uses_rs1 && (head.rs1 != 5'd0);
   assign rs2_chk      = head.uses_rs2 && (head.rs2 != 5'd0);
   assign issue_now    = !empty && !system_stall && !flush && !hazard_c;
   assign hazard_stall = !empty && hazard_c;

   // FIFO storage; payload only, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_uop;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (issue_now) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(issue_now);
      end
   end

   // Issue register: load on issue, clear on bubble, hold while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_valid            <= 1'b0;
         issue_instruction_type <= '0;
         issue_funct3           <= '0;
         issue_funct7           <= '0;
         issue_immediate        <= '0;
         issue_rs1              <= '0;
         issue_rs2              <= '0;
         issue_rd               <= '0;
      end else if (flush) begin
         issue_valid <= 1'b0;
      end else if (issue_now) begin
         issue_valid            <= 1'b1;
         issue_instruction_type <= head.instruction_type;
         issue_funct3           <= head.funct3;
         issue_funct7           <= head.funct7;
         issue_immediate        <= head.immediate;
         issue_rs1              <= head.rs1;
         issue_rs2              <= head.rs2;
         issue_rd               <= head.rd;
      end else if (!system_stall) begin
         issue_valid <= 1'b0;
      end
   end

   generate
      if (HAZ_DEPTH > 1) begin : g_trk
         localparam int NSLOT = int'(HAZ_DEPTH) - 1;

         logic [NSLOT-1:0] slot_v;
         logic [4:0]       slot_rd [NSLOT];
         logic             hz;

         // Shift register of in-flight destinations; slot0 is the youngest.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               slot_v <= '0;
               for (int i = 0; i < NSLOT; i++) begin
                  slot_rd[i] <= '0;
               end
            end else if (flush) begin
               slot_v <= '0;
            end else if (!system_stall) begin
               slot_v[0]  <= issue_now && head.writes_rd && (head.rd != 5'd0);
               slot_rd[0] <= head.rd;
               for (int i = 1; i < NSLOT; i++) begin
                  slot_v[i]  <= slot_v[i-1];
                  slot_rd[i] <= slot_rd[i-1];
               end
            end
         end

         // Head sources against every valid in-flight destination.
         always_comb begin
            hz = 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
               if (slot_v[i] && rs1_chk && (slot_rd[i] == head.rs1)) begin
                  hz = 1'b1;
               end
               if (slot_v[i] && rs2_chk && (slot_rd[i] == head.rs2)) begin
                  hz = 1'b1;
               end
            end
         end

         assign hazard_c = hz;
      end else begin : g_no_trk
         assign hazard_c = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl with hand-computed expectations.
module tb_exe_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        system_stall;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_instruction_type;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [20:0] in_immediate;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic        in_uses_rs1;
   logic        in_uses_rs2;
   logic        in_writes_rd;
   logic        issue_valid;
   logic [6:0]  issue_instruction_type;
   logic [2:0]  issue_funct3;
   logic [6:0]  issue_funct7;
   logic [20:0] issue_immediate;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [4:0]  issue_rd;
   logic [2:0]  count;
   logic        hazard_stall;

   int n_cmp = 0;
   int n_err = 0;

   exe_issue_ctrl #(.DEPTH(4), .HAZ_DEPTH(3)) u_dut (
      .clk                    (clk),
      .reset                  (reset),
      .flush                  (flush),
      .system_stall           (system_stall),
      .in_valid               (in_valid),
      .in_ready               (in_ready),
      .in_instruction_type    (in_instruction_type),
      .in_funct3              (in_funct3),
      .in_funct7              (in_funct7),
      .in_immediate           (in_immediate),
      .in_rd                  (in_rd),
      .in_rs1                 (in_rs1),
      .in_rs2                 (in_rs2),
      .in_uses_rs1            (in_uses_rs1),
      .in_uses_rs2            (in_uses_rs2),
      .in_writes_rd           (in_writes_rd),
      .issue_valid            (issue_valid),
      .issue_instruction_type (issue_instruction_type),
      .issue_funct3           (issue_funct3),
      .issue_funct7           (issue_funct7),
      .issue_immediate        (issue_immediate),
      .issue_rs1              (issue_rs1),
      .issue_rs2              (issue_rs2),
      .issue_rd               (issue_rd),
      .count                  (count),
      .hazard_stall           (hazard_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic wr, input logic [20:0] imm);
      in_valid            = v;
      in_rd               = rd;
      in_rs1              = rs1;
      in_uses_rs1         = u1;
      in_writes_rd        = wr;
      in_immediate        = imm;
      in_rs2              = 5'd0;
      in_uses_rs2         = 1'b0;
      in_instruction_type = 7'h33;
      in_funct3           = 3'd0;
      in_funct7           = 7'd0;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 21'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      int  pushed;
      int  popped;
      logic acc;

      reset        = 1'b0;
      flush        = 1'b0;
      system_stall = 1'b0;
      idle();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(issue_valid), 0);
      check("rst_count", 32'(count), 0);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_hz", 32'(hazard_stall), 0);
      check("rst_rd", 32'(issue_rd), 0);
      check("rst_imm", 32'(issue_immediate), 0);
      reset = 1'b1;

      // Streaming: 4 independent uops, issue 2 cycles after accept
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(i + 1), 5'd0, 1'b0, 1'b1, 21'(i));
         step();
         if (i == 0) begin
            check("strm_cnt0", 32'(count), 1);
            check("strm_v0", 32'(issue_valid), 0);
         end else begin
            check("strm_v", 32'(issue_valid), 1);
            check("strm_rd", 32'(issue_rd), 32'(i));
         end
      end
      idle();
      step();
      check("strm_v4", 32'(issue_valid), 1);
      check("strm_rd4", 32'(issue_rd), 4);
      check("strm_type", 32'(issue_instruction_type), 32'h33);
      step();
      check("strm_end_v", 32'(issue_valid), 0);
      check("strm_end_cnt", 32'(count), 0);

      // RAW hazard: B depends on A (rd=5)
      drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 21'h1);
      step();
      drive(1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 21'h2);
      step();
      check("haz_a_v", 32'(issue_valid), 1);
      check("haz_a_rd", 32'(issue_rd), 5);
      check("haz_hz0", 32'(hazard_stall), 1);
      idle();
      step();
      check("haz_bub1_v", 32'(issue_valid), 0);
      check("haz_hz1", 32'(hazard_stall), 1);
      step();
      check("haz_bub2_v", 32'(issue_valid), 0);
      check("haz_hz2", 32'(hazard_stall), 0);
      step();
      check("haz_b_v", 32'(issue_valid), 1);
      check("haz_b_rs1", 32'(issue_rs1), 5);
      check("haz_b_imm", 32'(issue_immediate), 2);
      step();
      check("haz_end_v", 32'(issue_valid), 0);

      // No hazard when producer does not write rd
      drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 21'h3);
      step();
      drive(1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 21'h4);
      step();
      check("nohz_a_v", 32'(issue_valid), 1);
      check("nohz_hz", 32'(hazard_stall), 0);
      idle();
      step();
      check("nohz_b_v", 32'(issue_valid), 1);
      check("nohz_b_imm", 32'(issue_immediate), 4);
      step();
      check("nohz_end_v", 32'(issue_valid), 0);

      // Stall: X held for 3 cycles, dependent Y spaced by HAZ_DEPTH+3
      drive(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 21'h11);
      step();
      idle();
      step();
      check("stl_x_v", 32'(issue_valid), 1);
      check("stl_x_rd", 32'(issue_rd), 8);
      system_stall = 1'b1;
      drive(1'b1, 5'd9, 5'd8, 1'b1, 1'b0, 21'h21);
      step();
      check("stl_h1_v", 32'(issue_valid), 1);
      check("stl_h1_imm", 32'(issue_immediate), 32'h11);
      check("stl_h1_cnt", 32'(count), 1);
      drive(1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 21'h22);
      step();
      check("stl_h2_imm", 32'(issue_immediate), 32'h11);
      check("stl_h2_cnt", 32'(count), 2);
      drive(1'b1, 5'd11, 5'd0, 1'b0, 1'b0, 21'h23);
      step();
      check("stl_h3_v", 32'(issue_valid), 1);
      check("stl_h3_rd", 32'(issue_rd), 8);
      check("stl_h3_cnt", 32'(count), 3);
      system_stall = 1'b0;
      drive(1'b1, 5'd12, 5'd0, 1'b0, 1'b0, 21'h24);
      step();
      check("stl_full_cnt", 32'(count), 4);
      check("stl_full_rdy", 32'(in_ready), 0);
      check("stl_b1_v", 32'(issue_valid), 0);
      check("stl_b1_hz", 32'(hazard_stall), 1);
      drive(1'b1, 5'd13, 5'd0, 1'b0, 1'b0, 21'h25);
      step();
      check("stl_b2_cnt", 32'(count), 4);
      check("stl_b2_v", 32'(issue_valid), 0);
      check("stl_b2_hz", 32'(hazard_stall), 0);
      idle();
      step();
      check("stl_y_v", 32'(issue_valid), 1);
      check("stl_y_imm", 32'(issue_immediate), 32'h21);
      check("stl_y_cnt", 32'(count), 3);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stl_z_v", 32'(issue_valid), 1);
         check("stl_z_imm", 32'(issue_immediate), 32'(32'h22 + i));
      end
      step();
      check("stl_end_v", 32'(issue_valid), 0);
      check("stl_end_cnt", 32'(count), 0);

      // Flush with 3 queued, 1 issued, rd=7 tracked; flush beats stall
      drive(1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 21'h31);
      step();
      drive(1'b1, 5'd13, 5'd0, 1'b0, 1'b0, 21'h32);
      step();
      check("fl_p_rd", 32'(issue_rd), 7);
      system_stall = 1'b1;
      drive(1'b1, 5'd14, 5'd0, 1'b0, 1'b0, 21'h33);
      step();
      drive(1'b1, 5'd15, 5'd0, 1'b0, 1'b0, 21'h34);
      step();
      check("fl_pre_cnt", 32'(count), 3);
      check("fl_pre_v", 32'(issue_valid), 1);
      flush = 1'b1;
      drive(1'b1, 5'd16, 5'd0, 1'b0, 1'b0, 21'h35);
      #1;
      check("fl_rdy", 32'(in_ready), 0);
      step();
      flush        = 1'b0;
      system_stall = 1'b0;
      check("fl_cnt", 32'(count), 0);
      check("fl_v", 32'(issue_valid), 0);
      check("fl_hz", 32'(hazard_stall), 0);
      drive(1'b1, 5'd20, 5'd7, 1'b1, 1'b1, 21'h36);
      step();
      check("fl_n_cnt", 32'(count), 1);
      check("fl_n_v0", 32'(issue_valid), 0);
      idle();
      step();
      check("fl_n_v", 32'(issue_valid), 1);
      check("fl_n_rs1", 32'(issue_rs1), 7);
      check("fl_n_imm", 32'(issue_immediate), 32'h36);
      step();
      check("fl_end_v", 32'(issue_valid), 0);
      check("fl_end_cnt", 32'(count), 0);

      // Wrap-around: 10 uops, one dependent pair to build a backlog
      pushed = 0;
      popped = 0;
      for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
         if (pushed < 10) begin
            drive(1'b1, 5'(16 + pushed), (pushed == 4) ? 5'd19 : 5'd0, (pushed == 4),
                  1'b1, 21'(100 + pushed));
         end else begin
            idle();
         end
         acc = in_valid && in_ready;
         step();
         if (acc) pushed++;
         if (issue_valid) begin
            check("wrap_imm", 32'(issue_immediate), 32'(100 + popped));
            popped++;
         end
         check("wrap_cnt_le4", 32'(count <= 3'd4), 1);
      end
      check("wrap_all", 32'(popped), 10);
      idle();
      step();
      step();

      // Async reset mid-stream while full and issuing
      drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 21'h41);
      step();
      drive(1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 21'h42);
      step();
      system_stall = 1'b1;
      drive(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 21'h43);
      step();
      drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 21'h44);
      step();
      drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 21'h45);
      step();
      idle();
      check("ar_pre_cnt", 32'(count), 4);
      check("ar_pre_v", 32'(issue_valid), 1);
      #3;
      reset = 1'b0;
      #1;
      check("ar_v", 32'(issue_valid), 0);
      check("ar_cnt", 32'(count), 0);
      check("ar_rd", 32'(issue_rd), 0);
      check("ar_imm", 32'(issue_immediate), 0);
      check("ar_rdy", 32'(in_ready), 1);
      system_stall = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      check("ar_hold_cnt", 32'(count), 0);
      drive(1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 21'h46);
      step();
      idle();
      step();
      check("ar_post_v", 32'(issue_valid), 1);
      check("ar_post_imm", 32'(issue_immediate), 32'h46);
      step();
      check("ar_post_end", 32'(issue_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
